xps2par: RTL and testbench
==========================

XPS2PAR -- requirements
Module: xps2par

Interface
REQ-001 SHALL have parameter DATA_ADDR, default 0, regf word receiving the scan code.
REQ-002 SHALL have parameter FLAG_ADDR, default 1, regf word used as the host/controller handshake flag.
REQ-003 SHALL have parameter TIMEOUT, default 5000, clk cycles of PS/2 inactivity that abort a partial frame.
REQ-004 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port ps2_clk  input  1  PS/2 device clock, asynchronous to clk.
REQ-007 SHALL have port ps2_data  input  1  PS/2 device data, asynchronous to clk.
REQ-008 SHALL have port par_addr  output  REGF_ADDR_W  register file host address.
REQ-009 SHALL have port par_we  output  1  register file host write enable.
REQ-010 SHALL have port par_in  output  DATA_W  write data to register file.
REQ-011 SHALL have port par_out  input  DATA_W  read data from register file, valid one clk after par_addr is presented.
REQ-012 SHALL have port ovf  output  1  sticky FIFO-overflow flag.

Function
REQ-013 SHALL synchronise ps2_clk and ps2_data through two flops each; a falling edge is sync_clk 1 then 0.
REQ-014 SHALL sample sync_data on each falling edge into an 11-bit frame: start 0, 8 data bits LSB first, odd parity, stop 1.
REQ-015 SHALL discard a frame whose start bit is 1 or whose stop bit is 0; the bit counter returns to 0.
REQ-016 SHALL clear the bit counter when TIMEOUT cycles elapse without a falling edge while the counter is nonzero.
REQ-017 SHALL push each accepted byte into a 4-entry FIFO one cycle after the stop-bit edge.
REQ-018 SHALL drop the incoming byte and set ovf when the FIFO is full; ovf clears only on reset.
REQ-019 SHALL allow a simultaneous push and pop, including when full, with no loss and no ovf.
REQ-020 SHALL run a host FSM with states IDLE, POLL, CHECK, WDATA, WFLAG.
REQ-021 IDLE: par_we=0; go to POLL when the FIFO is not empty.
REQ-022 POLL: drive par_addr=FLAG_ADDR, par_we=0; go to CHECK next cycle.
REQ-023 CHECK: if par_out==0, go to WDATA; otherwise go to POLL.
REQ-024 WDATA: one cycle with par_addr=DATA_ADDR, par_we=1, par_in={zero-extended FIFO head}; pop the FIFO.
REQ-025 WFLAG: one cycle with par_addr=FLAG_ADDR, par_we=1, par_in=1; then return to IDLE.
REQ-026 SHALL never write the flag register except in WFLAG; the controller consumes DATA_ADDR and then writes FLAG_ADDR=0.
REQ-027 SHALL drive par_addr=FLAG_ADDR and par_in=0 in IDLE; par_we is high only in WDATA and WFLAG.
REQ-028 Best-case latency from the stop-bit falling edge to the WDATA write SHALL be 6 clk cycles: 2 sync, 1 push, POLL, CHECK, WDATA.

Reset
REQ-029 On rst SHALL immediately set the FSM to IDLE, empty the FIFO, and clear the bit counter, the timeout counter and ovf.
REQ-030 On rst SHALL drive par_we=0, par_in=0, par_addr=FLAG_ADDR and ovf=0.
REQ-031 rst during a frame SHALL discard that frame; reception restarts at the next start bit after release.

Configuration
REQ-032 With PS2_PARITY_CHK_EN defined, SHALL discard a frame with even parity across data plus parity bit and SHALL NOT push it.
REQ-033 Without PS2_PARITY_CHK_EN, SHALL ignore the parity bit; only the start and stop checks apply.

Structure
REQ-034 Shared header xps2defs.vh SHALL hold the frame length (11), FIFO depth (4), FIFO pointer width and the FSM state encodings.
REQ-035 Frame reception (REQ-013 to REQ-016) SHALL be sub-module xps2rx, outputting an 8-bit byte and a one-cycle valid strobe.

Verification
REQ-036 Frame for 0x1C with correct parity, flag=0 -> DATA_ADDR=0x1C, then FLAG_ADDR=1, 6 cycles after the stop edge.
REQ-037 Flag held at 1 while 0x1C, 0x32, 0x21, 0x23, 0x2B arrive -> FSM stays in POLL/CHECK, ovf=1, 0x2B dropped; clearing the flag five times delivers 0x1C, 0x32, 0x21, 0x23 in order.
REQ-038 Frame for 0x5A with the parity bit inverted -> no write with PS2_PARITY_CHK_EN defined; 0x5A written without it.
REQ-039 Five bits of a frame, then a TIMEOUT+1 cycle gap, then a full 0x45 frame -> exactly one write, of 0x45.
REQ-040 rst asserted mid-frame and mid-WDATA -> par_we drops in the same cycle, FIFO empties, and the next valid frame is delivered normally.

Source files
------------

// File: rtl/xps2par_pkg.sv
// Shared constants and types for the PS/2 keyboard to register-file bridge:
// frame length, FIFO geometry, register-file widths and host FSM encodings.
package xps2par_pkg;

  localparam int FRAME_LEN   = 11;
  localparam int FIFO_DEPTH  = 4;
  localparam int FIFO_PTR_W  = 2;
  localparam int REGF_ADDR_W = 4;
  localparam int DATA_W      = 16;

  localparam logic [FIFO_PTR_W:0] FIFO_FULL_CNT = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_POLL  = 3'd1,
    ST_CHECK = 3'd2,
    ST_WDATA = 3'd3,
    ST_WFLAG = 3'd4
  } host_state_e;

  // Odd parity holds when data bits plus parity bit contain an odd number of ones.
  function automatic logic odd_parity_ok(input logic [8:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/xps2par_if.sv
// Register-file host port: address, write enable and write data from the bridge,
// read data (one clk after the address) back from the register file.
interface xps2par_if;
  import xps2par_pkg::*;

  logic [REGF_ADDR_W-1:0] par_addr;
  logic                   par_we;
  logic [DATA_W-1:0]      par_in;
  logic [DATA_W-1:0]      par_out;

  modport master (output par_addr, output par_we, output par_in, input par_out);
  modport slave  (input par_addr, input par_we, input par_in, output par_out);

endinterface

// File: rtl/xps2par_rx.sv
// PS/2 frame receiver: synchronises the device lines, assembles 11-bit frames and
// strobes out accepted bytes. Parity is enforced only when PS2_PARITY_CHK_EN is defined.
module xps2rx
  import xps2par_pkg::*;
#(
  parameter int TIMEOUT = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] byte_o,
  output logic       valid_o
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  logic [1:0]       clk_sync_q, data_sync_q;
  logic             clk_prev_q;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [8:0]       shift_q, shift_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             sync_clk, sync_data, fall;

  assign sync_clk  = clk_sync_q[1];
  assign sync_data = data_sync_q[1];
  assign fall      = clk_prev_q & ~sync_clk;
  assign byte_o    = shift_q[7:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      tmo_q       <= '0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
      data_sync_q <= {data_sync_q[0], ps2_data_i};
      clk_prev_q  <= sync_clk;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tmo_q       <= tmo_d;
    end
  end

  // The stop-bit edge strobes valid combinationally so the FIFO push lands on the next clk.
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tmo_d     = tmo_q;
    valid_o   = 1'b0;
    if (fall) begin
      tmo_d = '0;
      if (bit_cnt_q == 4'd0) begin
        if (!sync_data) bit_cnt_d = 4'd1;
      end else if (bit_cnt_q == 4'(FRAME_LEN - 1)) begin
        bit_cnt_d = 4'd0;
`ifdef PS2_PARITY_CHK_EN
        valid_o = sync_data & odd_parity_ok(shift_q);
`else
        valid_o = sync_data;
`endif
      end else begin
        shift_d   = {sync_data, shift_q[8:1]};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else if (bit_cnt_q != 4'd0) begin
      if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
        tmo_d     = '0;
        bit_cnt_d = 4'd0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/xps2par.sv
// PS/2 to register-file bridge: received scan codes queue in a 4-entry FIFO and are
// handed to the controller via a DATA/FLAG handshake. Optional PS2_PARITY_CHK_EN.
module xps2par
  import xps2par_pkg::*;
#(
  parameter int DATA_ADDR = 0,
  parameter int FLAG_ADDR = 1,
  parameter int TIMEOUT   = 5000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ps2_clk,
  input  logic         ps2_data,
  xps2par_if.master    par,
  output logic         ovf
);

  logic [7:0]            rx_byte;
  logic                  rx_valid;
  logic [7:0]            fifo_mem [FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_PTR_W:0]   count_q;
  logic                  ovf_q;
  logic                  fifo_empty, fifo_full, push, pop, drop;
  logic [7:0]            fifo_head;
  host_state_e           state_q, state_d;

  xps2rx #(.TIMEOUT(TIMEOUT)) u_rx (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk_i (ps2_clk),
    .ps2_data_i(ps2_data),
    .byte_o    (rx_byte),
    .valid_o   (rx_valid)
  );

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FIFO_FULL_CNT);
  assign fifo_head  = fifo_mem[rd_ptr_q];
  assign pop        = (state_q == ST_WDATA) && !fifo_empty;
  // A pop in the same cycle frees the head slot, so a full FIFO still accepts the byte.
  assign push       = rx_valid && (!fifo_full || pop);
  assign drop       = rx_valid && fifo_full && !pop;
  assign ovf        = ovf_q;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= rx_byte;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      state_q  <= ST_IDLE;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
      if (drop) ovf_q <= 1'b1;
      state_q <= state_d;
    end
  end

  // Outputs are decoded from state only, so an asynchronous reset drops par_we at once.
  always_comb begin
    state_d      = state_q;
    par.par_addr = REGF_ADDR_W'(FLAG_ADDR);
    par.par_we   = 1'b0;
    par.par_in   = '0;
    case (state_q)
      ST_IDLE:  if (!fifo_empty) state_d = ST_POLL;
      ST_POLL:  state_d = ST_CHECK;
      ST_CHECK: state_d = (par.par_out == '0) ? ST_WDATA : ST_POLL;
      ST_WDATA: begin
        par.par_addr = REGF_ADDR_W'(DATA_ADDR);
        par.par_we   = 1'b1;
        par.par_in   = DATA_W'(fifo_head);
        state_d      = ST_WFLAG;
      end
      ST_WFLAG: begin
        par.par_we = 1'b1;
        par.par_in = DATA_W'(1);
        state_d    = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_xps2par.sv
// Scoreboard bench for xps2par: a behavioural register file plays the controller,
// expected bytes are queued when frames are sent and checked on each DATA write.
module tb_xps2par;
  import xps2par_pkg::*;

  localparam int         TMO    = 200;
  localparam int         HALF   = 10;
  localparam logic [3:0] DATA_A = 4'd0;
  localparam logic [3:0] FLAG_A = 4'd1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  logic ovf;

  xps2par_if bus();

  xps2par #(.DATA_ADDR(0), .FLAG_ADDR(1), .TIMEOUT(TMO)) dut (
    .clk     (clk),
    .rst     (rst),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .par     (bus),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int stop_cyc = 0;
  int wr_cnt = 0;
  int last_wr_cyc = 0;
  bit prev_data = 1'b0;
  bit auto_clear = 1'b1;
  int clr_req = 0;
  int clr_done = 0;
  logic [7:0]  sb[$];
  logic [15:0] regf [16] = '{default: 16'h0};
  logic [15:0] rdata = 16'h0;

  assign bus.par_out = rdata;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Register file with one-cycle read; the controller side clears the flag.
  always @(posedge clk) begin
    if (bus.par_we) regf[bus.par_addr] <= bus.par_in;
    else if (auto_clear ? (regf[FLAG_A] != 16'h0) : (clr_done != clr_req)) begin
      regf[FLAG_A] <= 16'h0;
      if (!auto_clear) clr_done <= clr_done + 1;
    end
    rdata <= regf[bus.par_addr];
  end

  always @(negedge clk) begin
    if (rst) begin
      prev_data <= 1'b0;
    end else begin
      if (prev_data)
        chk("wflag_follows", {31'b0, bus.par_we && bus.par_addr == FLAG_A}, 1);
      if (bus.par_we && bus.par_addr == FLAG_A)
        chk("wflag_val", bus.par_in, 1);
      if (bus.par_we && bus.par_addr == DATA_A) begin
        if (sb.size() == 0) chk("unexpected_wr", bus.par_in, 32'hFFFF_FFFF);
        else chk("wdata", bus.par_in, {24'b0, sb.pop_front()});
        $display("write DATA=0x%02h at cycle %0d", bus.par_in[7:0], cyc);
        wr_cnt      <= wr_cnt + 1;
        last_wr_cyc <= cyc;
        prev_data   <= 1'b1;
      end else begin
        prev_data <= 1'b0;
      end
    end
  end

  task automatic ps2_send(input logic [7:0] b, input bit bad_par, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      repeat (HALF / 2) @(negedge clk);
      ps2_clk = 1'b0;
      if (i == 10) stop_cyc = cyc;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (HALF / 2) @(negedge clk);
    end
    ps2_data = 1'b1;
  endtask

  task automatic wait_wr(input int target, input int budget, input string tag);
    for (int i = 0; i < budget && wr_cnt < target; i++) @(negedge clk);
    chk(tag, wr_cnt, target);
  endtask

  initial begin
    int  base;
    bit  found;
    logic [7:0] burst [5];
    burst = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h2B};

    repeat (3) @(negedge clk);
    chk("rst_we", bus.par_we, 0);
    chk("rst_in", bus.par_in, 0);
    chk("rst_addr", bus.par_addr, FLAG_A);
    chk("rst_ovf", ovf, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Single frame, best-case latency
    base = wr_cnt;
    sb.push_back(8'h1C);
    ps2_send(8'h1C, 1'b0, 11);
    wait_wr(base + 1, 100, "t1_deliver");
    chk("t1_latency", last_wr_cyc - stop_cyc, 6);
    repeat (10) @(negedge clk);

    // Inverted parity bit
    base = wr_cnt;
`ifndef PS2_PARITY_CHK_EN
    sb.push_back(8'h5A);
`endif
    ps2_send(8'h5A, 1'b1, 11);
    repeat (60) @(negedge clk);
`ifdef PS2_PARITY_CHK_EN
    chk("t2_wr_cnt", wr_cnt, base);
`else
    chk("t2_wr_cnt", wr_cnt, base + 1);
`endif
    chk("t2_sb_empty", sb.size(), 0);

    // Partial frame abandoned by the inactivity timeout
    base = wr_cnt;
    ps2_send(8'hA5, 1'b0, 5);
    repeat (TMO + 1) @(negedge clk);
    sb.push_back(8'h45);
    ps2_send(8'h45, 1'b0, 11);
    repeat (100) @(negedge clk);
    chk("t3_wr_cnt", wr_cnt, base + 1);
    chk("t3_sb_empty", sb.size(), 0);

    // Flag held high: FIFO fills, fifth byte dropped, then drained in order
    auto_clear = 1'b0;
    base = wr_cnt;
    sb.push_back(8'h11);
    ps2_send(8'h11, 1'b0, 11);
    wait_wr(base + 1, 100, "t4_prime");
    repeat (10) @(negedge clk);
    base = wr_cnt;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) sb.push_back(burst[i]);
      ps2_send(burst[i], 1'b0, 11);
    end
    repeat (20) @(negedge clk);
    chk("t4_no_wr", wr_cnt, base);
    chk("t4_ovf", ovf, 1);
    chk("t4_we_low", bus.par_we, 0);
    for (int k = 0; k < 5; k++) begin
      clr_req++;
      wait_wr(base + ((k < 4) ? k + 1 : 4), 60, "t4_drain");
      repeat (5) @(negedge clk);
    end
    chk("t4_sb_empty", sb.size(), 0);
    chk("t4_ovf_sticky", ovf, 1);
    auto_clear = 1'b1;

    // Reset mid-frame
    ps2_send(8'h77, 1'b0, 5);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_rst_we", bus.par_we, 0);
    chk("t5_rst_ovf", ovf, 0);
    chk("t5_rst_addr", bus.par_addr, FLAG_A);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    base = wr_cnt;
    sb.push_back(8'h3C);
    ps2_send(8'h3C, 1'b0, 11);
    wait_wr(base + 1, 100, "t5_after_rst");

    // Reset while the DATA write is on the bus
    repeat (10) @(negedge clk);
    sb.push_back(8'h29);
    ps2_send(8'h29, 1'b0, 10);
    ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    ps2_clk = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (bus.par_we && bus.par_addr == DATA_A) found = 1'b1;
    end
    chk("t5_wdata_seen", {31'b0, found}, 1);
    #2 rst = 1'b1;
    #1;
    chk("t5_we_drop", bus.par_we, 0);
    chk("t5_addr_flag", bus.par_addr, FLAG_A);
    repeat (3) @(negedge clk);
    ps2_clk = 1'b1;
    rst = 1'b0;
    base = wr_cnt;
    repeat (40) @(negedge clk);
    chk("t5_fifo_empty", wr_cnt, base);
    sb.push_back(8'h16);
    ps2_send(8'h16, 1'b0, 11);
    wait_wr(base + 1, 100, "t5_next_frame");
    repeat (10) @(negedge clk);
    chk("final_sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
